// File: rtl/sqrt_key_entry.sv
// Keypad front end for the BCD square-root stage: collects up to six digits,
// holds the operand for a settle window on ENTER, then captures the root.
module sqrt_key_entry #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [23:0] in_dec,
  input  logic [23:0] out_dec,
  output logic [23:0] disp_dec,
  output logic [2:0]  digit_cnt,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] KEY_CLEAR   = 4'hA;
  localparam logic [3:0] KEY_BKSP    = 4'hB;
  localparam logic [3:0] KEY_ENTER   = 4'hC;

  // ENTRY: collecting digits | SETTLE: operand frozen, waiting | SHOW: result on display
  typedef enum logic [1:0] {
    S_ENTRY  = 2'd0,
    S_SETTLE = 2'd1,
    S_SHOW   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [23:0] entry, entry_nxt;
  logic [23:0] result, result_nxt;
  logic [2:0]  cnt_nxt;
  logic [3:0]  settle_cnt, settle_nxt;
  logic        done_nxt;
  logic        is_digit;

  assign is_digit = (key_code <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ENTRY;
      entry      <= '0;
      result     <= '0;
      digit_cnt  <= '0;
      settle_cnt <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      entry      <= entry_nxt;
      result     <= result_nxt;
      digit_cnt  <= cnt_nxt;
      settle_cnt <= settle_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    entry_nxt  = entry;
    result_nxt = result;
    cnt_nxt    = digit_cnt;
    settle_nxt = settle_cnt;
    done_nxt   = 1'b0;
    case (state)
      S_ENTRY: begin
        if (key_valid) begin
          if (is_digit) begin
            if (digit_cnt < 3'd6) begin
              entry_nxt = {entry[19:0], key_code};
              cnt_nxt   = digit_cnt + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
          end else if (key_code == KEY_BKSP) begin
            entry_nxt = {4'h0, entry[23:4]};
            if (digit_cnt != 3'd0) cnt_nxt = digit_cnt - 3'd1;
          end else if (key_code == KEY_ENTER) begin
            settle_nxt = SETTLE_INIT;
            state_nxt  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        // keys are dropped here, including one arriving on the capture edge
        if (settle_cnt == 4'd0) begin
          result_nxt = out_dec;
          done_nxt   = 1'b1;
          state_nxt  = S_SHOW;
        end else begin
          settle_nxt = settle_cnt - 4'd1;
        end
      end
      S_SHOW: begin
        if (key_valid) begin
          if (is_digit) begin
            entry_nxt = {20'h0, key_code};
            cnt_nxt   = 3'd1;
            state_nxt = S_ENTRY;
          end else if (key_code == KEY_CLEAR) begin
            entry_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = S_ENTRY;
          end else if (key_code == KEY_BKSP) begin
            state_nxt = S_ENTRY;
          end else if (key_code == KEY_ENTER) begin
            settle_nxt = SETTLE_INIT;
            state_nxt  = S_SETTLE;
          end
        end
      end
      default: state_nxt = S_ENTRY;
    endcase
  end

  assign in_dec   = entry;
  assign disp_dec = (state == S_SHOW) ? result : entry;
  assign busy     = (state == S_SETTLE);

endmodule

// File: tb/tb_sqrt_key_entry.sv
// Randomized bench for sqrt_key_entry against a digit-queue reference model;
// the square-root stage is modelled as integer sqrt over decimal values.
module tb_sqrt_key_entry;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [23:0] in_dec, out_dec, disp_dec;
  logic [2:0]  digit_cnt;
  logic        busy, done;

  int total = 0;
  int bad = 0;

  // reference model
  int q[$];
  int m_state = 0;   // 0 entry, 1 settle, 2 show
  int m_left = 0;
  int m_res = 0;
  bit m_done = 0;

  sqrt_key_entry #(.SETTLE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .in_dec(in_dec), .out_dec(out_dec), .disp_dec(disp_dec),
    .digit_cnt(digit_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int isqrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] b = '0;
    for (int i = 0; i < 6; i++) begin
      b[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic int from_bcd(logic [23:0] b);
    int v = 0;
    for (int i = 5; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  always_comb out_dec = to_bcd(isqrt(from_bcd(in_dec)));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int q_value();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic logic [23:0] q_packed();
    logic [23:0] p = '0;
    foreach (q[i]) p = {p[19:0], 4'(q[i])};
    return p;
  endfunction

  task automatic model_edge(input bit v, input int c, input bit r);
    if (r) begin
      q.delete(); m_state = 0; m_res = 0; m_done = 0; m_left = 0;
      return;
    end
    m_done = 0;
    if (m_state == 1) begin
      if (m_left == 0) begin
        m_res = isqrt(q_value()); m_done = 1; m_state = 2;
      end else m_left--;
    end else if (v) begin
      if (c <= 9) begin
        if (m_state == 2) begin q.delete(); q.push_back(c); m_state = 0; end
        else if (q.size() < 6) q.push_back(c);
      end else if (c == 10) begin
        q.delete(); m_state = 0;
      end else if (c == 11) begin
        if (m_state == 0 && q.size() > 0) void'(q.pop_back());
        m_state = 0;
      end else if (c == 12) begin
        m_left = N - 1; m_state = 1;
      end
    end
  endtask

  task automatic step(input bit v, input int c, input bit r);
    @(negedge clk);
    key_valid = v; key_code = 4'(c); rst = r;
    @(posedge clk);
    model_edge(v, c, r);
    #1;
    check("in_dec", 32'(in_dec), 32'(q_packed()));
    check("disp_dec", 32'(disp_dec), 32'(m_state == 2 ? to_bcd(m_res) : q_packed()));
    check("digit_cnt", 32'(digit_cnt), 32'(q.size()));
    check("busy", 32'(busy), 32'(m_state == 1));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic press(input int c); step(1, c, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 0); endtask

  initial begin
    step(0, 0, 1); step(0, 0, 1);
    check("rst_disp", 32'(disp_dec), 32'h0);

    press(1); press(4); press(4);
    check("in_144", 32'(in_dec), 32'h144);
    press(12); idle(N);
    check("res_144", 32'(disp_dec), 32'h12);

    press(10);
    for (int i = 0; i < 7; i++) press(9);
    check("cnt_full", 32'(digit_cnt), 32'd6);
    press(12); idle(N + 1);
    check("res_999999", 32'(disp_dec), 32'h999);

    press(10); press(1); press(2); press(3);
    for (int i = 0; i < 4; i++) press(11);
    check("bksp_floor", 32'(digit_cnt), 32'd0);

    press(12); idle(N); press(5);
    check("show_digit", 32'(in_dec), 32'h5);

    press(10); press(2); press(5); press(12); press(7); press(10); idle(N - 2);
    check("res_25", 32'(disp_dec), 32'h5);
    press(11); press(12); idle(N + 2);

    press(10); press(8); press(1); press(12); idle(2); step(0, 0, 1); idle(N + 2);
    check("rst_settle", 32'(disp_dec), 32'h0);

    for (int i = 0; i < 2000; i++) begin
      int r1, c;
      r1 = $urandom_range(0, 199);
      if (r1 == 0) step(0, 0, 1);
      else if (r1 < 130) begin
        c = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 15);
        press(c);
      end else idle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
